// File: rtl/brq_ifu_prefetch_buffer_nreq.sv
// brq_ifu_prefetch_buffer_nreq
// Instruction prefetch buffer that keeps up to NUM_REQS granted bus requests
// in flight and queues returned words in a FIFO_DEPTH-entry registered FIFO.
//
// Parameters:
//   NUM_REQS   max outstanding granted bus requests (1..4)
//   FIFO_DEPTH fetched-word FIFO entries (NUM_REQS..8)
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   req_i, branch_i, addr_i fetch enable, redirect/flush, redirect target
//   ready_i                 consumer accepts head word
//   valid_o, rdata_o,
//   addr_o, err_o           head word, its aligned address and fetch error
//   busy_o                  request pending or responses outstanding
//   instr_*                 bus request/grant/response channel
// Configuration:
//   BRQ_IFU_PF_PMP_ERR_EN   when defined, instr_pmp_err_i on a request acts
//                           as a grant and yields an in-order error response.
module brq_ifu_prefetch_buffer_nreq #(
  parameter int unsigned NUM_REQS   = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] addr_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic [31:0] addr_o,
  output logic        err_o,
  output logic        busy_o,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        instr_err_i,
  input  logic        instr_pmp_err_i
);

  localparam int unsigned OCW = $clog2(NUM_REQS + 1);
  localparam int unsigned DCW = $clog2(NUM_REQS + 2);
  localparam int unsigned FCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned FAW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [31:0]    fetch_addr;
  logic [31:0]    held_addr;
  logic [31:0]    resp_addr;
  logic           held;
  logic [OCW-1:0] out_cnt;
  logic [DCW-1:0] disc_cnt;
  logic [FCW-1:0] fifo_cnt;
  logic           valid_q;
  logic [31:0]    fifo_data [FIFO_DEPTH];
  logic [31:0]    fifo_addr [FIFO_DEPTH];
  logic           fifo_err  [FIFO_DEPTH];

  logic [31:0]    target_c;
  logic [31:0]    req_addr_c;
  logic [31:0]    rsp_data_c;
  logic           issue_c;
  logic           req_c;
  logic           grant_c;
  logic           rvalid_c;
  logic           rsp_err_c;
  logic           push_c;
  logic           pop_c;
  logic           pmp_block_c;
  logic [FCW-1:0] wr_idx_c;
  logic [FCW-1:0] fifo_cnt_n_c;
  logic [OCW-1:0] out_cnt_n_c;
  logic [DCW-1:0] disc_cnt_n_c;

`ifdef BRQ_IFU_PF_PMP_ERR_EN
  logic pmp_pend;
  logic pmp_grant_c;
  logic pmp_rvalid_c;
`else
  logic unused_pmp_err;
  assign unused_pmp_err = instr_pmp_err_i;
`endif

  // Request issue, bus handshake and response bookkeeping
  always_comb begin
`ifdef BRQ_IFU_PF_PMP_ERR_EN
    // A faulted request must retire before anything younger is issued, so
    // its synthetic response lands behind all earlier bus responses.
    pmp_block_c  = pmp_pend;
`else
    pmp_block_c  = 1'b0;
`endif
    target_c     = {addr_i[31:2], 2'b00};
    issue_c      = req_i && !rst_i && !held && !pmp_block_c &&
                   (32'(out_cnt) < NUM_REQS) &&
                   ((32'(fifo_cnt) + 32'(out_cnt) < FIFO_DEPTH) || branch_i);
    req_c        = (held && !rst_i) || issue_c;
    req_addr_c   = held ? held_addr : (branch_i ? target_c : fetch_addr);
`ifdef BRQ_IFU_PF_PMP_ERR_EN
    pmp_grant_c  = req_c && instr_pmp_err_i;
    pmp_rvalid_c = pmp_pend && (out_cnt == OCW'(1));
    instr_req_o  = req_c && !instr_pmp_err_i;
    grant_c      = req_c && (instr_gnt_i || instr_pmp_err_i);
    rvalid_c     = instr_rvalid_i || pmp_rvalid_c;
    rsp_err_c    = instr_err_i || pmp_rvalid_c;
    rsp_data_c   = pmp_rvalid_c ? 32'd0 : instr_rdata_i;
`else
    instr_req_o  = req_c;
    grant_c      = req_c && instr_gnt_i;
    rvalid_c     = instr_rvalid_i;
    rsp_err_c    = instr_err_i;
    rsp_data_c   = instr_rdata_i;
`endif
    instr_addr_o = req_addr_c;
    busy_o       = instr_req_o || (out_cnt != '0);

    // Responses for requests issued before a redirect are dropped
    push_c       = rvalid_c && !branch_i && (disc_cnt == '0);
    pop_c        = valid_q && ready_i && !branch_i;
    wr_idx_c     = pop_c ? (fifo_cnt - FCW'(1)) : fifo_cnt;
    fifo_cnt_n_c = branch_i ? '0 : (fifo_cnt + FCW'(push_c) - FCW'(pop_c));

    out_cnt_n_c  = out_cnt;
    if (grant_c && !rvalid_c) begin
      out_cnt_n_c = out_cnt + OCW'(1);
    end else if (!grant_c && rvalid_c) begin
      out_cnt_n_c = out_cnt - OCW'(1);
    end

    disc_cnt_n_c = disc_cnt;
    if (branch_i) begin
      disc_cnt_n_c = DCW'(out_cnt) + DCW'(held) - DCW'(rvalid_c);
    end else if (rvalid_c && (disc_cnt != '0)) begin
      disc_cnt_n_c = disc_cnt - DCW'(1);
    end
  end

  // State registers and shift-style FIFO (entry 0 is the head)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_addr <= '0;
      held_addr  <= '0;
      resp_addr  <= '0;
      held       <= 1'b0;
      out_cnt    <= '0;
      disc_cnt   <= '0;
      fifo_cnt   <= '0;
      valid_q    <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data[FAW'(i)] <= '0;
        fifo_addr[FAW'(i)] <= '0;
        fifo_err[FAW'(i)]  <= 1'b0;
      end
`ifdef BRQ_IFU_PF_PMP_ERR_EN
      pmp_pend   <= 1'b0;
`endif
    end else begin
      // A request issued in the redirect cycle already used the target
      if (branch_i) begin
        fetch_addr <= target_c + (issue_c ? 32'd4 : 32'd0);
      end else if (issue_c) begin
        fetch_addr <= fetch_addr + 32'd4;
      end
      held <= req_c && !grant_c;
      if (issue_c) begin
        held_addr <= req_addr_c;
      end
      out_cnt  <= out_cnt_n_c;
      disc_cnt <= disc_cnt_n_c;
      fifo_cnt <= fifo_cnt_n_c;
      valid_q  <= (fifo_cnt_n_c != '0);
      if (branch_i) begin
        resp_addr <= target_c;
      end else if (push_c) begin
        resp_addr <= resp_addr + 32'd4;
      end
      if (pop_c) begin
        for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) begin
          fifo_data[FAW'(i)] <= fifo_data[FAW'(i + 1)];
          fifo_addr[FAW'(i)] <= fifo_addr[FAW'(i + 1)];
          fifo_err[FAW'(i)]  <= fifo_err[FAW'(i + 1)];
        end
      end
      if (push_c && (32'(wr_idx_c) < FIFO_DEPTH)) begin
        fifo_data[FAW'(wr_idx_c)] <= rsp_data_c;
        fifo_addr[FAW'(wr_idx_c)] <= resp_addr;
        fifo_err[FAW'(wr_idx_c)]  <= rsp_err_c;
      end
`ifdef BRQ_IFU_PF_PMP_ERR_EN
      if (pmp_grant_c) begin
        pmp_pend <= 1'b1;
      end else if (pmp_rvalid_c) begin
        pmp_pend <= 1'b0;
      end
`endif
    end
  end

  // Issue throttling must make a push into a full FIFO impossible
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(push_c && !pop_c && (32'(fifo_cnt) >= FIFO_DEPTH)));
    end
  end

  assign valid_o = valid_q;
  assign rdata_o = fifo_data[0];
  assign addr_o  = fifo_addr[0];
  assign err_o   = fifo_err[0];

endmodule

// File: tb/tb_brq_ifu_prefetch_buffer_nreq.sv
// Self-checking bench for brq_ifu_prefetch_buffer_nreq (NUM_REQS=3,
// FIFO_DEPTH=4). A bus responder replies in order from a queue of granted
// addresses; expected words come from an address-indexed memory function.
module tb_brq_ifu_prefetch_buffer_nreq;

  localparam int unsigned NR = 3;
  localparam int unsigned FD = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_i;
  logic        branch_i;
  logic [31:0] addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] rdata_o;
  logic [31:0] addr_o;
  logic        err_o;
  logic        busy_o;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        instr_err_i;
  logic        instr_pmp_err_i;

  always #5 clk_i = ~clk_i;

  brq_ifu_prefetch_buffer_nreq #(.NUM_REQS(NR), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i),
    .addr_i(addr_i), .ready_i(ready_i), .valid_o(valid_o), .rdata_o(rdata_o),
    .addr_o(addr_o), .err_o(err_o), .busy_o(busy_o),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
    .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i),
    .instr_rdata_i(instr_rdata_i), .instr_err_i(instr_err_i),
    .instr_pmp_err_i(instr_pmp_err_i)
  );

  int errors = 0;
  int checks = 0;

  logic [31:0] bq[$];           // granted, not yet answered bus addresses
  int          gnt_pct = 100;
  int          rv_pct  = 100;
  bit          pmp_on  = 1'b0;
  logic [31:0] pmp_addr = 32'h0;
  bit          cur_rv;
  logic [31:0] cur_rv_addr;
  bit          cur_gnt;
  bit          prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'h0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic mem_err(input logic [31:0] a);
    return a[6:2] == 5'd11;
  endfunction

  // Drive one cycle's inputs; leaves time 3 units after the rising edge
  task automatic cycle_begin(input bit br, input logic [31:0] tgt, input bit rq, input bit rdy);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0; branch_i = br; addr_i = tgt; req_i = rq; ready_i = rdy;
    cur_rv = (bq.size() != 0) && ($urandom_range(99) < rv_pct);
    instr_rvalid_i = cur_rv;
    if (cur_rv) begin
      cur_rv_addr   = bq[0];
      instr_rdata_i = mem_data(bq[0]);
      instr_err_i   = mem_err(bq[0]);
    end else begin
      cur_rv_addr   = 32'h0;
      instr_rdata_i = $urandom;
      instr_err_i   = 1'b0;
    end
    instr_gnt_i = 1'b0;
    instr_pmp_err_i = 1'b0;
    #1;
    if (pmp_on && instr_req_o && instr_addr_o == pmp_addr) instr_pmp_err_i = 1'b1;
    cur_gnt = instr_req_o && ($urandom_range(99) < gnt_pct);
    instr_gnt_i = cur_gnt;
    #1;
  endtask

  task automatic cycle_end();
    if (cur_rv) void'(bq.pop_front());
    if (cur_gnt) bq.push_back(instr_addr_o);
    prev_hold = instr_req_o && !cur_gnt;
    prev_addr = instr_addr_o;
  endtask

  task automatic settle();
    int k = 0;
    gnt_pct = 100; rv_pct = 100;
    while ((bq.size() != 0 || prev_hold) && k < 30) begin
      cycle_begin(1'b0, 32'h0, 1'b0, 1'b1);
      cycle_end();
      k++;
    end
    if (bq.size() != 0 || prev_hold) begin
      checks++; errors++;
      $display("FAIL settle_timeout: outstanding=%0d held=%0b required 0/0", bq.size(), prev_hold);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1; req_i = 1'b1; branch_i = 1'b1; addr_i = 32'h1234; ready_i = 1'b1;
    instr_gnt_i = 1'b1; instr_rvalid_i = 1'b0; instr_rdata_i = 32'hFFFF_FFFF;
    instr_err_i = 1'b1; instr_pmp_err_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk_i);
      if (c == 2) begin
        #1; rst_i = 1'b0; req_i = 1'b0; branch_i = 1'b0; instr_gnt_i = 1'b0; #2;
      end else begin
        #3;
      end
      checks += 6;
      if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid c%0d: got %b want 0", c, valid_o); end
      if (instr_req_o !== 1'b0) begin errors++; $display("FAIL reset_req c%0d: got %b want 0", c, instr_req_o); end
      if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy c%0d: got %b want 0", c, busy_o); end
      if (rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata c%0d: got %h want 0", c, rdata_o); end
      if (addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr c%0d: got %h want 0", c, addr_o); end
      if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err c%0d: got %b want 0", c, err_o); end
    end
    prev_hold = 1'b0;
  endtask

  task automatic test_branch_seq();
    logic [31:0] got[3];
    int nreq = 0, rv_k = -1, val_k = -1;
    logic [31:0] first_addr = 32'hDEAD_BEEF;
    settle();
    for (int k = 0; k < 8; k++) begin
      cycle_begin(k == 0, 32'h0000_1002, 1'b1, 1'b1);
      if (instr_req_o && !prev_hold && nreq < 3) begin got[nreq] = instr_addr_o; nreq++; end
      if (cur_rv && cur_rv_addr == 32'h1000 && rv_k < 0) rv_k = k;
      if (k >= 1 && valid_o && val_k < 0) begin val_k = k; first_addr = addr_o; end
      cycle_end();
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= nreq || got[i] !== 32'h1000 + 32'(4 * i)) begin
        errors++; $display("FAIL seq_req_addr%0d: got %h want %h", i, got[i], 32'h1000 + 32'(4 * i));
      end
    end
    checks++;
    if (first_addr !== 32'h1000) begin errors++; $display("FAIL seq_first_addr: got %h want 00001000", first_addr); end
    checks++;
    if (rv_k < 0 || val_k !== rv_k + 1) begin errors++; $display("FAIL seq_latency: valid at %0d want %0d", val_k, rv_k + 1); end
  endtask

  task automatic test_outstanding_limit();
    int ngr = 0, bad = 0;
    settle();
    gnt_pct = 100; rv_pct = 0;
    for (int k = 0; k < 8; k++) begin
      cycle_begin(k == 0, 32'h4000, 1'b1, 1'b1);
      if (ngr >= int'(NR) && instr_req_o) bad++;
      if (cur_gnt) ngr++;
      cycle_end();
    end
    checks++;
    if (ngr !== int'(NR)) begin errors++; $display("FAIL limit_grants: got %0d want %0d", ngr, NR); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL limit_req_low: got %0d req cycles want 0", bad); end
    rv_pct = 100;
    cycle_begin(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (!cur_rv || instr_req_o !== 1'b0) begin errors++; $display("FAIL limit_rv_cycle: rv=%0b req=%b want 1/0", cur_rv, instr_req_o); end
    cycle_end();
    rv_pct = 0;
    cycle_begin(1'b0, 32'h0, 1'b1, 1'b1);
    checks++;
    if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h400C) begin
      errors++; $display("FAIL limit_resume: req=%b addr=%h want 1/0000400c", instr_req_o, instr_addr_o);
    end
    cycle_end();
  endtask

  task automatic test_branch_flush();
    int val_k = -1;
    logic [31:0] fa = 32'hDEAD_BEEF, fd = 32'h0;
    settle();
    gnt_pct = 100; rv_pct = 0;
    for (int k = 0; k < 12; k++) begin
      if (k == 3) rv_pct = 100;
      cycle_begin(k == 0 || k == 2, (k == 0) ? 32'h5000 : 32'h2000, 1'b1, 1'b1);
      if (k >= 3 && valid_o && val_k < 0) begin val_k = k; fa = addr_o; fd = rdata_o; end
      cycle_end();
    end
    checks++;
    if (fa !== 32'h2000) begin errors++; $display("FAIL flush_first_addr: got %h want 00002000", fa); end
    checks++;
    if (fd !== mem_data(32'h2000)) begin errors++; $display("FAIL flush_first_data: got %h want %h", fd, mem_data(32'h2000)); end
    checks++;
    if (val_k !== 6) begin errors++; $display("FAIL flush_timing: first valid at %0d want 6", val_k); end
  endtask

  task automatic test_backpressure();
    int ngr = 0;
    settle();
    gnt_pct = 100; rv_pct = 100;
    for (int k = 0; k < 16; k++) begin
      cycle_begin(k == 0, 32'h6000, 1'b1, 1'b0);
      if (cur_gnt) ngr++;
      cycle_end();
    end
    checks++;
    if (ngr !== int'(FD)) begin errors++; $display("FAIL bp_grants: got %0d want %0d", ngr, FD); end
    for (int k = 0; k < 5; k++) begin
      cycle_begin(1'b0, 32'h0, 1'b0, 1'b1);
      checks++;
      if (k < 4) begin
        if (valid_o !== 1'b1 || addr_o !== 32'h6000 + 32'(4 * k) || rdata_o !== mem_data(32'h6000 + 32'(4 * k))) begin
          errors++; $display("FAIL bp_drain%0d: valid=%b addr=%h want 1/%h", k, valid_o, addr_o, 32'h6000 + 32'(4 * k));
        end
      end else if (valid_o !== 1'b0) begin
        errors++; $display("FAIL bp_empty: valid=%b want 0", valid_o);
      end
      cycle_end();
    end
  endtask

`ifdef BRQ_IFU_PF_PMP_ERR_EN
  task automatic test_pmp();
    int bus_bad = 0, np = 0;
    logic [31:0] pa[3];
    logic        pe[3];
    settle();
    gnt_pct = 100; rv_pct = 100; pmp_on = 1'b1; pmp_addr = 32'h3004;
    for (int k = 0; k < 12; k++) begin
      cycle_begin(k == 0, 32'h3000, 1'b1, 1'b1);
      if (instr_req_o && instr_addr_o == 32'h3004) bus_bad++;
      if (k >= 1 && valid_o && np < 3) begin pa[np] = addr_o; pe[np] = err_o; np++; end
      cycle_end();
    end
    pmp_on = 1'b0;
    checks++;
    if (bus_bad !== 0) begin errors++; $display("FAIL pmp_no_bus_req: got %0d want 0", bus_bad); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= np || pa[i] !== 32'h3000 + 32'(4 * i) ||
          pe[i] !== ((i == 1) ? 1'b1 : mem_err(32'h3000 + 32'(4 * i)))) begin
        errors++; $display("FAIL pmp_word%0d: addr=%h err=%b want %h", i, pa[i], pe[i], 32'h3000 + 32'(4 * i));
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] exp_addr = 32'h0, exp_req = 32'h0, tgt;
    bit br, rq, rdy;
    int pops = 0, after;
    settle();
    gnt_pct = 60; rv_pct = 50;
    for (int k = 0; k < 3000; k++) begin
      br  = (k == 0) || ($urandom_range(99) < 3);
      tgt = $urandom;
      rq  = $urandom_range(99) < 90;
      rdy = $urandom_range(99) < 70;
      cycle_begin(br, tgt, rq, rdy);
      checks++;
      if (prev_hold) begin
        if (instr_req_o !== 1'b1 || instr_addr_o !== prev_addr) begin
          errors++; $display("FAIL rnd_hold k%0d: req=%b addr=%h want 1/%h", k, instr_req_o, instr_addr_o, prev_addr);
        end
      end else if (!rq && instr_req_o !== 1'b0) begin
        errors++; $display("FAIL rnd_idle_req k%0d: got %b want 0", k, instr_req_o);
      end
      if (br) exp_req = {tgt[31:2], 2'b00};
      if (instr_req_o === 1'b1 && !prev_hold) begin
        checks++;
        if (instr_addr_o !== exp_req) begin errors++; $display("FAIL rnd_req_addr k%0d: got %h want %h", k, instr_addr_o, exp_req); end
        exp_req += 32'd4;
      end
      checks++;
      if (busy_o !== (instr_req_o | (bq.size() != 0))) begin
        errors++; $display("FAIL rnd_busy k%0d: got %b want %b", k, busy_o, instr_req_o | (bq.size() != 0));
      end
      after = bq.size() + int'(cur_gnt) - int'(cur_rv);
      checks++;
      if (after > int'(NR)) begin errors++; $display("FAIL rnd_outstanding k%0d: got %0d want <=%0d", k, after, NR); end
      if (br) begin
        exp_addr = {tgt[31:2], 2'b00};
      end else if (valid_o === 1'b1 && rdy) begin
        checks++;
        if (addr_o !== exp_addr || rdata_o !== mem_data(exp_addr) || err_o !== mem_err(exp_addr)) begin
          errors++; $display("FAIL rnd_word k%0d: addr=%h data=%h err=%b want %h/%h/%b",
                             k, addr_o, rdata_o, err_o, exp_addr, mem_data(exp_addr), mem_err(exp_addr));
        end
        exp_addr += 32'd4;
        pops++;
      end
      cycle_end();
    end
    checks++;
    if (pops < 200) begin errors++; $display("FAIL rnd_progress: got %0d pops want >=200", pops); end
  endtask

  initial begin
    test_reset();
    test_branch_seq();
    test_outstanding_limit();
    test_branch_flush();
    test_backpressure();
`ifdef BRQ_IFU_PF_PMP_ERR_EN
    test_pmp();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
